// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard detection and operand forwarding.
// Tracks every in-flight register write in a DEPTH-entry slot pipeline behind D
// (slot 0 = E ... slot DEPTH-1 = W). Results are captured as they become
// available, the youngest ready match is forwarded to the D operands, D stalls
// while a needed value is outstanding, and the last slot drives write-back.
module hazard_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic             issue_reg_write,
    input  logic             issue_is_load,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [XLEN-1:0]  source1D,
    input  logic [XLEN-1:0]  source2D,
    input  logic [XLEN-1:0]  alu_resultE,
    input  logic [XLEN-1:0]  load_data,
    input  logic             flush,
    output logic [XLEN-1:0]  reg_data1D,
    output logic [XLEN-1:0]  reg_data2D,
    output logic             stall,
    output logic             stall_load,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_is_load;
    logic [DEPTH-1:0] r_ready;
    logic [4:0]       r_rd   [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];
    logic [CNT_W-1:0] r_stall_cnt;

    logic            w_found1, w_found2;
    logic            w_haz1, w_haz2;
    logic            w_haz1_ld, w_haz2_ld;
    logic [XLEN-1:0] w_fwd1, w_fwd2;
    logic            w_stall;
    logic            w_issue;

    // Youngest-match search per source; an unready youngest match blocks older ready ones.
    always_comb begin
        w_found1  = 1'b0;
        w_found2  = 1'b0;
        w_haz1    = 1'b0;
        w_haz2    = 1'b0;
        w_haz1_ld = 1'b0;
        w_haz2_ld = 1'b0;
        w_fwd1    = source1D;
        w_fwd2    = source2D;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!w_found1 && r_valid[i] && (rs1D != 5'd0) && (r_rd[i] == rs1D)) begin
                w_found1 = 1'b1;
                if (r_ready[i]) begin
                    w_fwd1 = r_data[i];
                end else begin
                    w_haz1    = use_rs1;
                    w_haz1_ld = use_rs1 & r_is_load[i];
                end
            end
            if (!w_found2 && r_valid[i] && (rs2D != 5'd0) && (r_rd[i] == rs2D)) begin
                w_found2 = 1'b1;
                if (r_ready[i]) begin
                    w_fwd2 = r_data[i];
                end else begin
                    w_haz2    = use_rs2;
                    w_haz2_ld = use_rs2 & r_is_load[i];
                end
            end
        end
    end

    assign w_stall = w_haz1 | w_haz2;
    assign w_issue = issue_valid & ~w_stall & ~flush & issue_reg_write & (issue_rd != 5'd0);

    // Slot pipeline: slot 0 takes the D instruction or a bubble, the rest always shift.
    // Data is captured from the ALU on the 0->1 move and from load_data on the move
    // into slot LOAD_LAT; the later assignment wins when LOAD_LAT is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_is_load <= '0;
            r_ready   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0]   <= w_issue;
            r_rd[0]      <= issue_rd;
            r_is_load[0] <= w_issue & issue_is_load;
            r_ready[0]   <= 1'b0;
            r_data[0]    <= '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_valid[i]   <= r_valid[i-1];
                r_rd[i]      <= r_rd[i-1];
                r_is_load[i] <= r_is_load[i-1];
                r_ready[i]   <= r_ready[i-1];
                r_data[i]    <= r_data[i-1];
                if ((i == 1) && !r_is_load[i-1]) begin
                    r_ready[i] <= 1'b1;
                    r_data[i]  <= alu_resultE;
                end
                if ((i == LOAD_LAT) && r_is_load[i-1]) begin
                    r_ready[i] <= 1'b1;
                    r_data[i]  <= load_data;
                end
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall        = ~rst & w_stall;
    assign stall_load   = ~rst & (w_haz1_ld | w_haz2_ld);
    assign reg_data1D   = rst ? source1D : w_fwd1;
    assign reg_data2D   = rst ? source2D : w_fwd2;
    assign wb_valid     = ~rst & r_valid[DEPTH-1];
    assign wb_rd        = wb_valid ? r_rd[DEPTH-1] : 5'd0;
    assign wb_data      = wb_valid ? r_data[DEPTH-1] : '0;
    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: cycle table on the default configuration with a
// write-back scoreboard, plus hand sequences for LOAD_LAT=1 and a 3-bit counter.
module tb_hazard_scoreboard;

    localparam logic [31:0] S1 = 32'hAAAA0001;
    localparam logic [31:0] S2 = 32'hBBBB0002;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, issue_valid, issue_reg_write, issue_is_load, flush;
    logic [4:0]  issue_rd, rs1D, rs2D;
    logic        use_rs1, use_rs2;
    logic [31:0] source1D, source2D, alu_resultE, load_data;

    logic [31:0] m_r1, m_r2, m_wb_data, m_cnt;
    logic        m_stall, m_sl, m_wb_valid;
    logic [4:0]  m_wb_rd;
    logic [31:0] l_r1, l_r2, l_wb_data, l_cnt;
    logic        l_stall, l_sl, l_wb_valid;
    logic [4:0]  l_wb_rd;
    logic [31:0] c_r1, c_r2, c_wb_data;
    logic [2:0]  c_cnt;
    logic        c_stall, c_sl, c_wb_valid;
    logic [4:0]  c_wb_rd;

    hazard_scoreboard #(.XLEN(32), .DEPTH(3), .LOAD_LAT(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load),
        .rs1D(rs1D), .rs2D(rs2D), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .source1D(source1D), .source2D(source2D), .alu_resultE(alu_resultE),
        .load_data(load_data), .flush(flush), .reg_data1D(m_r1), .reg_data2D(m_r2),
        .stall(m_stall), .stall_load(m_sl), .wb_valid(m_wb_valid), .wb_rd(m_wb_rd),
        .wb_data(m_wb_data), .stall_cycles(m_cnt));

    hazard_scoreboard #(.XLEN(32), .DEPTH(3), .LOAD_LAT(1), .CNT_W(32)) dut_l1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load),
        .rs1D(rs1D), .rs2D(rs2D), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .source1D(source1D), .source2D(source2D), .alu_resultE(alu_resultE),
        .load_data(load_data), .flush(flush), .reg_data1D(l_r1), .reg_data2D(l_r2),
        .stall(l_stall), .stall_load(l_sl), .wb_valid(l_wb_valid), .wb_rd(l_wb_rd),
        .wb_data(l_wb_data), .stall_cycles(l_cnt));

    hazard_scoreboard #(.XLEN(32), .DEPTH(12), .LOAD_LAT(11), .CNT_W(3)) dut_c3 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load),
        .rs1D(rs1D), .rs2D(rs2D), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .source1D(source1D), .source2D(source2D), .alu_resultE(alu_resultE),
        .load_data(load_data), .flush(flush), .reg_data1D(c_r1), .reg_data2D(c_r2),
        .stall(c_stall), .stall_load(c_sl), .wb_valid(c_wb_valid), .wb_rd(c_wb_rd),
        .wb_data(c_wb_data), .stall_cycles(c_cnt));

    typedef struct {
        logic        rst, iv, rw, ld, fl, u1, u2;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] alu, ldd, pdata;
        logic        e_stall, e_sl, e_wb, cr1, cr2;
        logic [31:0] e_r1, e_r2, e_cnt;
    } vec_t;

    int tests  = 0;
    int failed = 0;
    logic [36:0] sbq[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t nv(input logic [31:0] cnt);
        vec_t v;
        v = '{default: '0};
        v.e_r1 = S1;
        v.e_r2 = S2;
        v.cr1 = 1'b1;
        v.cr2 = 1'b1;
        v.e_cnt = cnt;
        return v;
    endfunction

    function automatic vec_t iss(input logic [4:0] rd, input logic ld,
                                 input logic [31:0] pdata, input logic [31:0] cnt);
        vec_t v;
        v = nv(cnt);
        v.iv = 1'b1;
        v.rw = 1'b1;
        v.rd = rd;
        v.ld = ld;
        v.pdata = pdata;
        return v;
    endfunction

    task automatic clear_inputs();
        rst = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_reg_write = 1'b0;
        issue_is_load = 1'b0; flush = 1'b0; rs1D = '0; rs2D = '0; use_rs1 = 1'b0;
        use_rs2 = 1'b0; source1D = S1; source2D = S2; alu_resultE = '0; load_data = '0;
    endtask

    task automatic step(input vec_t v, input int idx);
        logic [36:0] e;
        rst = v.rst; issue_valid = v.iv; issue_rd = v.rd; issue_reg_write = v.rw;
        issue_is_load = v.ld; flush = v.fl; rs1D = v.rs1; rs2D = v.rs2;
        use_rs1 = v.u1; use_rs2 = v.u2; alu_resultE = v.alu; load_data = v.ldd;
        source1D = S1; source2D = S2;
        if (!v.rst && v.iv && v.rw && (v.rd != 5'd0) && !v.fl && !v.e_stall)
            sbq.push_back({v.rd, v.pdata});
        @(negedge clk);
        chk($sformatf("row%0d stall", idx), 64'(m_stall), 64'(v.e_stall));
        chk($sformatf("row%0d stall_load", idx), 64'(m_sl), 64'(v.e_sl));
        chk($sformatf("row%0d wb_valid", idx), 64'(m_wb_valid), 64'(v.e_wb));
        chk($sformatf("row%0d stall_cycles", idx), 64'(m_cnt), 64'(v.e_cnt));
        if (v.cr1) chk($sformatf("row%0d reg_data1D", idx), 64'(m_r1), 64'(v.e_r1));
        if (v.cr2) chk($sformatf("row%0d reg_data2D", idx), 64'(m_r2), 64'(v.e_r2));
        if (m_wb_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL row%0d wb_extra: got write-back rd=%0d expected none", idx, m_wb_rd);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("row%0d wb_rd", idx), 64'(m_wb_rd), 64'(e[36:32]));
                chk($sformatf("row%0d wb_data", idx), 64'(m_wb_data), 64'(e[31:0]));
            end
        end
        if (v.rst) sbq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // ALU producer x5 then dependent add x6,x5,x1
        v = nv(0); v.rst = 1; tbl.push_back(v);
        v = iss(5, 0, 32'h1234, 0); tbl.push_back(v);
        v = iss(6, 0, 32'h6666, 0); v.rs1 = 5; v.rs2 = 1; v.u1 = 1; v.u2 = 1;
        v.alu = 32'h1234; v.e_stall = 1; v.cr1 = 0; tbl.push_back(v);
        v = iss(6, 0, 32'h6666, 1); v.rs1 = 5; v.rs2 = 1; v.u1 = 1; v.u2 = 1;
        v.alu = 32'h0BAD; v.e_r1 = 32'h1234; tbl.push_back(v);
        v = nv(1); v.alu = 32'h6666; v.e_wb = 1; tbl.push_back(v);
        v = nv(1); tbl.push_back(v);
        v = nv(1); v.e_wb = 1; tbl.push_back(v);
        // load x7 then use of x7 in rs2: two load stalls
        v = iss(7, 1, 32'hDEADBEEF, 1); tbl.push_back(v);
        v = iss(8, 0, 32'h8888, 1); v.rs1 = 1; v.rs2 = 7; v.u1 = 1; v.u2 = 1;
        v.e_stall = 1; v.e_sl = 1; v.cr2 = 0; tbl.push_back(v);
        v = iss(8, 0, 32'h8888, 2); v.rs1 = 1; v.rs2 = 7; v.u1 = 1; v.u2 = 1;
        v.ldd = 32'hDEADBEEF; v.e_stall = 1; v.e_sl = 1; v.cr2 = 0; tbl.push_back(v);
        v = iss(8, 0, 32'h8888, 3); v.rs1 = 1; v.rs2 = 7; v.u1 = 1; v.u2 = 1;
        v.e_r2 = 32'hDEADBEEF; v.e_wb = 1; tbl.push_back(v);
        v = nv(3); v.alu = 32'h8888; tbl.push_back(v);
        v = nv(3); tbl.push_back(v);
        v = nv(3); v.e_wb = 1; tbl.push_back(v);
        // back-to-back x5 writes; youngest must win
        v = iss(5, 0, 32'h11, 3); tbl.push_back(v);
        v = iss(5, 0, 32'h22, 3); v.alu = 32'h11; tbl.push_back(v);
        v = iss(9, 0, 32'h99, 3); v.alu = 32'h22; tbl.push_back(v);
        v = iss(10, 0, 32'hAA, 3); v.alu = 32'h99; v.rs2 = 5; v.u2 = 1;
        v.e_r2 = 32'h22; v.e_wb = 1; tbl.push_back(v);
        v = nv(3); v.iv = 1; v.rs1 = 5; v.u1 = 1; v.alu = 32'hAA;
        v.e_r1 = 32'h22; v.e_wb = 1; tbl.push_back(v);
        v = nv(3); v.rs1 = 5; v.u1 = 1; v.e_wb = 1; tbl.push_back(v);
        v = nv(3); v.e_wb = 1; tbl.push_back(v);
        // write to x0 is never tracked
        v = iss(0, 0, 32'h0, 3); tbl.push_back(v);
        v = nv(3); v.u1 = 1; v.u2 = 1; v.alu = 32'h5555; tbl.push_back(v);
        v = nv(3); tbl.push_back(v);
        v = nv(3); tbl.push_back(v);
        // flushed producer leaves a bubble
        v = iss(11, 0, 32'h0, 3); v.fl = 1; tbl.push_back(v);
        v = nv(3); v.rs1 = 11; v.u1 = 1; v.alu = 32'h7777; tbl.push_back(v);
        v = nv(3); tbl.push_back(v);
        v = nv(3); tbl.push_back(v);
        // reset while a load sits in slot 1
        v = iss(12, 1, 32'hF00D, 3); tbl.push_back(v);
        v = nv(3); tbl.push_back(v);
        v = nv(3); v.rst = 1; v.rs1 = 12; v.u1 = 1; tbl.push_back(v);
        v = nv(0); v.rs1 = 12; v.u1 = 1; tbl.push_back(v);
        v = nv(0); tbl.push_back(v);
        v = nv(0); tbl.push_back(v);

        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        // LOAD_LAT=1: a dependent use stalls exactly one cycle
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        issue_valid = 1'b1; issue_reg_write = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("l1 issue stall", 64'(l_stall), 64'd0);
        @(posedge clk); #1;
        issue_rd = 5'd8; issue_is_load = 1'b0; rs2D = 5'd7; use_rs2 = 1'b1;
        load_data = 32'hCAFEF00D;
        @(negedge clk);
        chk("l1 use stall", 64'(l_stall), 64'd1);
        chk("l1 use stall_load", 64'(l_sl), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1 released stall", 64'(l_stall), 64'd0);
        chk("l1 reg_data2D", 64'(l_r2), 64'hCAFEF00D);
        chk("l1 stall_cycles", 64'(l_cnt), 64'd1);
        @(posedge clk); #1;

        // 3-bit counter saturates during an 11-cycle load stall
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        load_data = 32'h11112222;
        issue_valid = 1'b1; issue_reg_write = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd7;
        @(posedge clk); #1;
        issue_is_load = 1'b0; issue_rd = 5'd8; rs1D = 5'd7; use_rs1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("c3 k%0d stall", k), 64'(c_stall), (k < 11) ? 64'd1 : 64'd0);
            chk($sformatf("c3 k%0d stall_cycles", k), 64'(c_cnt), (k < 7) ? 64'(k) : 64'd7);
            if (k == 11) chk("c3 reg_data1D", 64'(c_r1), 64'h11112222);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
